// File: rtl/timer_pkg.sv
// Shared constants for timer_mc: register offsets, TCR/TSR bit positions,
// prescaler select encoding and the value driven on reserved reads.
package timer_pkg;

  localparam logic [2:0] OFF_TDR_L  = 3'd0;
  localparam logic [2:0] OFF_TDR_H  = 3'd1;
  localparam logic [2:0] OFF_TCR    = 3'd2;
  localparam logic [2:0] OFF_TSR    = 3'd3;
  localparam logic [2:0] OFF_TCNT_L = 3'd4;
  localparam logic [2:0] OFF_TCNT_H = 3'd5;

  localparam int TCR_LOAD = 7;
  localparam int TCR_DN   = 5;
  localparam int TCR_EN   = 4;
  localparam int TCR_IE   = 3;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  typedef enum logic [2:0] {
    CKS_DIV2   = 3'd0,
    CKS_DIV4   = 3'd1,
    CKS_DIV8   = 3'd2,
    CKS_DIV16  = 3'd3,
    CKS_DIV32  = 3'd4,
    CKS_DIV64  = 3'd5,
    CKS_DIV128 = 3'd6,
    CKS_DIV256 = 3'd7
  } cks_e;

  localparam logic [7:0] RSVD_RD = 8'h00;

  // tick[k] is high when pre[k:0] is all ones.
  function automatic logic [7:0] tick_vec(input logic [7:0] pre);
    logic [7:0] t;
    logic       run;
    run = 1'b1;
    for (int k = 0; k < 8; k++) begin
      run  = run & pre[k];
      t[k] = run;
    end
    return t;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reload register, control, W1C status, counter and the
// TCNT_H shadow byte. Auto-reload on wrap when TIMER_AUTO_RELOAD_EN is defined.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       tick,
  input  logic [7:0]       wdata,
  input  logic             we_tdr_l,
  input  logic             we_tdr_h,
  input  logic             we_tcr,
  input  logic             we_tsr,
  input  logic             rd_cnt_l,
  output logic [CNT_W-1:0] tdr,
  output logic [7:0]       tcr_rd,
  output logic [7:0]       tsr_rd,
  output logic [CNT_W-1:0] cnt,
  output logic [7:0]       shadow,
  output logic             irq
);

  logic [5:0]       tcr;
  logic             ovf, udf;
  logic             load, step;
  logic             set_ovf, set_udf;
  logic [CNT_W-1:0] cnt_nxt, wrap_up, wrap_dn;
  cks_e             cks;

  assign cks  = cks_e'(tcr[2:0]);
  assign load = we_tcr & wdata[TCR_LOAD];
  assign step = tcr[TCR_EN] & tick[cks];

`ifdef TIMER_AUTO_RELOAD_EN
  assign wrap_up = tdr;
  assign wrap_dn = tdr;
`else
  assign wrap_up = '0;
  assign wrap_dn = '1;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cnt_nxt = cnt;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    if (load) begin
      cnt_nxt = tdr;
    end else if (step) begin
      if (tcr[TCR_DN]) begin
        if (cnt == '0) begin
          cnt_nxt = wrap_dn;
          set_udf = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end else begin
        if (cnt == '1) begin
          cnt_nxt = wrap_up;
          set_ovf = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdr    <= '0;
      tcr    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      if (we_tdr_l) tdr[7:0] <= wdata;
      if (CNT_W == 16 && we_tdr_h) tdr[CNT_W-1 -: 8] <= wdata;
      if (we_tcr) tcr <= wdata[5:0];
      // A hardware set outranks a same-cycle W1C of that bit.
      ovf    <= set_ovf | (ovf & ~(we_tsr & wdata[TSR_OVF]));
      udf    <= set_udf | (udf & ~(we_tsr & wdata[TSR_UDF]));
      cnt    <= cnt_nxt;
      if (rd_cnt_l) shadow <= cnt[CNT_W-1 -: 8];
    end
  end

  assign tcr_rd = {2'b00, tcr};
  assign tsr_rd = {6'b000000, udf, ovf};
  assign irq    = tcr[TCR_IE] & (ovf | udf);

endmodule

// File: rtl/timer_mc.sv
// Multi-channel timer on an 8-bit APB-lite bus: shared prescaler, decode,
// read mux and pslverr. Optional auto-reload via TIMER_AUTO_RELOAD_EN.
module timer_mc
  import timer_pkg::*;
#(
  parameter int CH_NUM = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [CH_NUM-1:0] irq
);

  logic [7:0] pre;
  logic [7:0] tick;
  logic [4:0] ch;
  logic [2:0] off;
  logic       acc, off_ok, ch_ok, hit, wr, rd;

  logic [CNT_W-1:0] tdr_a    [CH_NUM];
  logic [CNT_W-1:0] cnt_a    [CH_NUM];
  logic [7:0]       tcr_a    [CH_NUM];
  logic [7:0]       tsr_a    [CH_NUM];
  logic [7:0]       shadow_a [CH_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre <= '0;
    else        pre <= pre + 8'd1;
  end

  assign tick = tick_vec(pre);

  assign ch  = paddr[7:3];
  assign off = paddr[2:0];
  assign acc = psel & penable;

  always_comb begin
    off_ok = 1'b0;
    case (off)
      OFF_TDR_L, OFF_TCR, OFF_TSR, OFF_TCNT_L: off_ok = 1'b1;
      OFF_TDR_H, OFF_TCNT_H:                   off_ok = (CNT_W == 16);
      default:                                 off_ok = 1'b0;
    endcase
  end

  assign ch_ok   = (ch < 5'(CH_NUM));
  assign hit     = ch_ok & off_ok;
  assign wr      = acc & pwrite & hit;
  assign rd      = acc & ~pwrite & hit;
  assign pready  = 1'b1;
  assign pslverr = acc & ~hit;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic sel;
    assign sel = (ch == 5'(c));

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .wdata    (pwdata),
      .we_tdr_l (wr & sel & (off == OFF_TDR_L)),
      .we_tdr_h (wr & sel & (off == OFF_TDR_H)),
      .we_tcr   (wr & sel & (off == OFF_TCR)),
      .we_tsr   (wr & sel & (off == OFF_TSR)),
      .rd_cnt_l (rd & sel & (off == OFF_TCNT_L)),
      .tdr      (tdr_a[c]),
      .tcr_rd   (tcr_a[c]),
      .tsr_rd   (tsr_a[c]),
      .cnt      (cnt_a[c]),
      .shadow   (shadow_a[c]),
      .irq      (irq[c])
    );
  end

  always_comb begin
    prdata = RSVD_RD;
    if (rd) begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (ch == 5'(c)) begin
          case (off)
            OFF_TDR_L:  prdata = tdr_a[c][7:0];
            OFF_TDR_H:  prdata = tdr_a[c][CNT_W-1 -: 8];
            OFF_TCR:    prdata = tcr_a[c];
            OFF_TSR:    prdata = tsr_a[c];
            OFF_TCNT_L: prdata = cnt_a[c][7:0];
            OFF_TCNT_H: prdata = shadow_a[c];
            default:    prdata = RSVD_RD;
          endcase
        end
      end
    end
  end

endmodule
